// File: rtl/stencil_stream_harness.sv
// stencil_stream_harness
// Streams a stored input image to a stencil kernel under test and checks
// the kernel's output stream against a stored expected image.
// The input image repeats indefinitely. A run ends when NUM_LOOPS output
// frames have been checked, when a mismatch is seen (if STOP_ON_ERROR is
// set), or when the watchdog expires. The result is reported on status
// ports rather than by halting, so the same checker works in simulation
// and on hardware.
module stencil_stream_harness #(
    parameter int PIXEL_W       = 8,
    parameter int IMG_W         = 4,
    parameter int IMG_H         = 4,
    parameter int NUM_LOOPS     = 1000,
    parameter int BP_MODE       = 0,
    parameter int STOP_ON_ERROR = 1,
    parameter int TIMEOUT       = 4096,
    localparam int OUT_W        = IMG_W - 2,
    localparam int OUT_H        = IMG_H - 2,
    localparam int IN_N         = IMG_W * IMG_H,
    localparam int OUT_N        = OUT_W * OUT_H,
    localparam int AW           = $clog2((IN_N > OUT_N) ? IN_N : OUT_N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               mem_we,
    input  logic               mem_sel,
    input  logic [AW-1:0]      mem_addr,
    input  logic [PIXEL_W-1:0] mem_wdata,
    output logic               dut_pixel_valid,
    output logic [PIXEL_W-1:0] dut_pixel_bits,
    input  logic               dut_pixel_ready,
    output logic               dut_imgw_valid,
    output logic [15:0]        dut_imgw_bits,
    input  logic               dut_imgw_ready,
    output logic               dut_imgh_valid,
    output logic [15:0]        dut_imgh_bits,
    input  logic               dut_imgh_ready,
    input  logic               dut_out_valid,
    input  logic [PIXEL_W-1:0] dut_out_bits,
    output logic               dut_out_ready,
    output logic               done,
    output logic               fail,
    output logic               timeout,
    output logic [31:0]        loops,
    output logic [31:0]        err_count,
    output logic [AW-1:0]      err_index,
    output logic [PIXEL_W-1:0] err_got,
    output logic [PIXEL_W-1:0] err_exp,
    output logic [31:0]        cycles
);

    // Memories span the full pointer range so every pointer value is a
    // legal index; only the first IN_N / OUT_N entries are ever written.
    localparam int              MEM_N     = 1 << AW;
    localparam logic [AW-1:0]   IN_LAST   = AW'(IN_N - 1);
    localparam logic [AW-1:0]   OUT_LAST  = AW'(OUT_N - 1);
    localparam logic [15:0]     LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    logic [PIXEL_W-1:0] in_mem_q  [MEM_N];
    logic [PIXEL_W-1:0] exp_mem_q [MEM_N];

    state_t             state_q,     state_d;
    logic               imgw_done_q, imgw_done_d;
    logic               imgh_done_q, imgh_done_d;
    logic [AW-1:0]      in_ptr_q,    in_ptr_d;
    logic [AW-1:0]      out_ptr_q,   out_ptr_d;
    logic [31:0]        loops_q,     loops_d;
    logic [31:0]        err_count_q, err_count_d;
    logic [AW-1:0]      err_index_q, err_index_d;
    logic [PIXEL_W-1:0] err_got_q,   err_got_d;
    logic [PIXEL_W-1:0] err_exp_q,   err_exp_d;
    logic               done_q,      done_d;
    logic               fail_q,      fail_d;
    logic               timeout_q,   timeout_d;
    logic [31:0]        cycles_q,    cycles_d;
    logic [31:0]        wdog_q,      wdog_d;
    logic               tog_q,       tog_d;
    logic [15:0]        lfsr_q,      lfsr_d;

    logic               px_hs;
    logic               out_hs;
    logic               mismatch;
    logic               lfsr_fb;
    logic               bp_ready;
    logic               in_addr_ok;
    logic               exp_addr_ok;

    // Address range checks are done at 32 bits: IN_N may equal 2**AW.
    assign in_addr_ok  = {{(32-AW){1'b0}}, mem_addr} < 32'(IN_N);
    assign exp_addr_ok = {{(32-AW){1'b0}}, mem_addr} < 32'(OUT_N);

    // Image loads are honoured only while idle, so a run always sees a
    // stable image. Contents survive reset.
    always_ff @(posedge clock) begin
        if (reset && state_q == S_IDLE && mem_we) begin
            if (!mem_sel && in_addr_ok) begin
                in_mem_q[mem_addr] <= mem_wdata;
            end
            if (mem_sel && exp_addr_ok) begin
                exp_mem_q[mem_addr] <= mem_wdata;
            end
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11, in right-shift form.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Output backpressure source selected by BP_MODE.
    always_comb begin
        bp_ready = 1'b1;
        if (BP_MODE == 1) begin
            bp_ready = tog_q;
        end else if (BP_MODE == 2) begin
            bp_ready = lfsr_q[0];
        end
    end

    assign dut_pixel_valid = (state_q == S_RUN);
    assign dut_pixel_bits  = in_mem_q[in_ptr_q];
    assign dut_imgw_valid  = (state_q == S_CONFIG) && !imgw_done_q;
    assign dut_imgh_valid  = (state_q == S_CONFIG) && !imgh_done_q;
    assign dut_imgw_bits   = 16'(IMG_W);
    assign dut_imgh_bits   = 16'(IMG_H);
    assign dut_out_ready   = (state_q == S_RUN) && bp_ready;

    assign px_hs  = dut_pixel_valid && dut_pixel_ready;
    assign out_hs = dut_out_valid && dut_out_ready;

    assign done      = done_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign loops     = loops_q;
    assign err_count = err_count_q;
    assign err_index = err_index_q;
    assign err_got   = err_got_q;
    assign err_exp   = err_exp_q;
    assign cycles    = cycles_q;

    // Next-state: sequencing, streaming pointers, checking and watchdog.
    always_comb begin
        state_d     = state_q;
        imgw_done_d = imgw_done_q;
        imgh_done_d = imgh_done_q;
        in_ptr_d    = in_ptr_q;
        out_ptr_d   = out_ptr_q;
        loops_d     = loops_q;
        err_count_d = err_count_q;
        err_index_d = err_index_q;
        err_got_d   = err_got_q;
        err_exp_d   = err_exp_q;
        done_d      = done_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        cycles_d    = cycles_q;
        wdog_d      = wdog_q;
        tog_d       = tog_q;
        lfsr_d      = lfsr_q;
        mismatch    = 1'b0;

        if (state_q == S_CONFIG || state_q == S_RUN) begin
            cycles_d = cycles_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CONFIG;
                end
            end

            S_CONFIG: begin
                // Width and height handshake independently; either order.
                if (dut_imgw_valid && dut_imgw_ready) begin
                    imgw_done_d = 1'b1;
                end
                if (dut_imgh_valid && dut_imgh_ready) begin
                    imgh_done_d = 1'b1;
                end
                if (imgw_done_d && imgh_done_d) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                tog_d  = ~tog_q;
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                wdog_d = wdog_q + 32'd1;

                if (px_hs) begin
                    in_ptr_d = (in_ptr_q == IN_LAST) ? '0 : in_ptr_q + 1'b1;
                end

                if (out_hs) begin
                    wdog_d = '0;
                    if (out_ptr_q == OUT_LAST) begin
                        out_ptr_d = '0;
                        loops_d   = loops_q + 32'd1;
                    end else begin
                        out_ptr_d = out_ptr_q + 1'b1;
                    end
                    if (dut_out_bits != exp_mem_q[out_ptr_q]) begin
                        mismatch = 1'b1;
                        if (err_count_q != 32'hFFFF_FFFF) begin
                            err_count_d = err_count_q + 32'd1;
                        end
                        // Only the first mismatch of a run is recorded.
                        if (!fail_q) begin
                            err_index_d = out_ptr_q;
                            err_got_d   = dut_out_bits;
                            err_exp_d   = exp_mem_q[out_ptr_q];
                        end
                        fail_d = 1'b1;
                    end
                end

                // A stopping mismatch outranks frame-count completion.
                if (mismatch && STOP_ON_ERROR != 0) begin
                    state_d = S_FAIL;
                end else if (loops_d == 32'(NUM_LOOPS)) begin
                    if (fail_d) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (wdog_d == 32'(TIMEOUT)) begin
                    state_d   = S_FAIL;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            S_FAIL: begin
                state_d = S_FAIL;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and status registers; synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            imgw_done_q <= 1'b0;
            imgh_done_q <= 1'b0;
            in_ptr_q    <= '0;
            out_ptr_q   <= '0;
            loops_q     <= '0;
            err_count_q <= '0;
            err_index_q <= '0;
            err_got_q   <= '0;
            err_exp_q   <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
            wdog_q      <= '0;
            tog_q       <= 1'b1;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            imgw_done_q <= imgw_done_d;
            imgh_done_q <= imgh_done_d;
            in_ptr_q    <= in_ptr_d;
            out_ptr_q   <= out_ptr_d;
            loops_q     <= loops_d;
            err_count_q <= err_count_d;
            err_index_q <= err_index_d;
            err_got_q   <= err_got_d;
            err_exp_q   <= err_exp_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            cycles_q    <= cycles_d;
            wdog_q      <= wdog_d;
            tog_q       <= tog_d;
            lfsr_q      <= lfsr_d;
        end
    end

endmodule
